// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared widths, encodings, typedefs and saturation helper
// for the partial-sum accumulator. The helper works on a 32-bit carrier, so ACC_DW <= 32.
package psum_acc_pkg;

    localparam int NUM_CH_D = 64;
    localparam int IN_DW_D  = 16;
    localparam int ACC_DW_D = 24;
    localparam int OUT_DW_D = 16;
    localparam int MAX_W    = 32;

    localparam logic CALCULATE = 1'b1;
    localparam logic DATAVALID = 1'b1;

    typedef logic signed [IN_DW_D-1:0]  psum_t;
    typedef logic signed [ACC_DW_D-1:0] acc_t;
    typedef logic signed [OUT_DW_D-1:0] res_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Clamp v to the signed range of a w-bit result.
    function automatic logic signed [MAX_W-1:0] psum_sat(
        input logic signed [MAX_W-1:0] v,
        input int unsigned             w
    );
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if: control, partial-sum input and result bundle.
// Ports: mode, beats_cfg, acc_clr, data_e, data_in -> DUT; data_out, data_e_out, acc_busy <- DUT.
interface psum_accumulator_if #(
    parameter int NUM_CH = 64,
    parameter int IN_DW  = 16,
    parameter int OUT_DW = 16
);

    logic                          mode;
    logic [7:0]                    beats_cfg;
    logic                          acc_clr;
    logic                          data_e;
    logic [NUM_CH-1:0][IN_DW-1:0]  data_in;
    logic [NUM_CH-1:0][OUT_DW-1:0] data_out;
    logic                          data_e_out;
    logic                          acc_busy;

    modport master (
        output mode,
        output beats_cfg,
        output acc_clr,
        output data_e,
        output data_in,
        input  data_out,
        input  data_e_out,
        input  acc_busy
    );

    modport slave (
        input  mode,
        input  beats_cfg,
        input  acc_clr,
        input  data_e,
        input  data_in,
        output data_out,
        output data_e_out,
        output acc_busy
    );

endinterface

// File: rtl/psum_acc_lane.sv
// psum_acc_lane: one channel's accumulator, output shift, clamp or wrap, and result register.
// Ports: clk, rst_n, clr_i, accept_i, first_i, last_i, din_i -> lane; dout_o <- lane. Macro: PSUM_ACC_SAT_EN.
module psum_acc_lane
    import psum_acc_pkg::*;
#(
    parameter int IN_DW     = 16,
    parameter int ACC_DW    = 24,
    parameter int OUT_DW    = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     accept_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic signed [IN_DW-1:0]  din_i,
    output logic signed [OUT_DW-1:0] dout_o
);

    logic signed [ACC_DW-1:0] acc_q;
    logic signed [ACC_DW-1:0] acc_d;
    logic signed [ACC_DW-1:0] acc_base;
    logic signed [ACC_DW-1:0] acc_next;
    logic signed [ACC_DW-1:0] shifted;
    logic signed [OUT_DW-1:0] res;
    logic signed [OUT_DW-1:0] dout_q;
    logic signed [OUT_DW-1:0] dout_d;
`ifdef PSUM_ACC_SAT_EN
    logic signed [MAX_W-1:0]  wide;
    logic signed [MAX_W-1:0]  sat;
`endif

    always_comb begin
        // A new pixel starts from zero regardless of stale accumulator contents.
        acc_base = first_i ? '0 : acc_q;
        acc_next = acc_base + ACC_DW'(din_i);
        shifted  = acc_next >>> OUT_SHIFT;
`ifdef PSUM_ACC_SAT_EN
        wide = MAX_W'(shifted);
        sat  = psum_sat(wide, OUT_DW);
        res  = OUT_DW'(sat);
`else
        res  = OUT_DW'(shifted);
`endif
    end

    always_comb begin
        acc_d  = acc_q;
        dout_d = dout_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (accept_i) begin
            if (last_i) begin
                acc_d  = '0;
                dout_d = res;
            end else begin
                acc_d  = acc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums beats_cfg partial-sum beats per pixel on NUM_CH lanes, emits one result pulse.
// Ports: clk, rst_n, bus (psum_accumulator_if.slave). Macro: PSUM_ACC_SAT_EN selects clamp over wrap.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_D,
    parameter int IN_DW     = IN_DW_D,
    parameter int ACC_DW    = ACC_DW_D,
    parameter int OUT_DW    = OUT_DW_D,
    parameter int OUT_SHIFT = 0
) (
    input logic clk,
    input logic rst_n,
    psum_accumulator_if.slave bus
);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] len_q;
    logic [7:0] len_d;
    logic       valid_q;
    logic       valid_d;

    logic       accept;
    logic       first;
    logic       last;
    logic [7:0] len_eff;
    logic [7:0] cnt_base;
    logic [8:0] cnt_inc;

    logic [OUT_DW-1:0] dout_w [NUM_CH];

    always_comb begin
        accept   = (bus.data_e == DATAVALID) && (bus.mode == CALCULATE)
                   && !bus.acc_clr;
        first    = accept && (state_q == ST_IDLE);
        // Length is sampled only on the first beat; a zero count means one beat.
        len_eff  = first ? ((bus.beats_cfg == 8'd0) ? 8'd1 : bus.beats_cfg)
                         : len_q;
        cnt_base = first ? 8'd0 : cnt_q;
        cnt_inc  = {1'b0, cnt_base} + 9'd1;
        last     = accept && (cnt_inc == {1'b0, len_eff});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        valid_d = 1'b0;
        unique case (1'b1)
            bus.acc_clr: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            accept && last: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                len_d   = len_eff;
                valid_d = DATAVALID;
            end
            accept && !last: begin
                state_d = ST_ACC;
                cnt_d   = cnt_inc[7:0];
                len_d   = len_eff;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        psum_acc_lane #(
            .IN_DW    (IN_DW),
            .ACC_DW   (ACC_DW),
            .OUT_DW   (OUT_DW),
            .OUT_SHIFT(OUT_SHIFT)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (bus.acc_clr),
            .accept_i(accept),
            .first_i (first),
            .last_i  (last),
            .din_i   (bus.data_in[g]),
            .dout_o  (dout_w[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            bus.data_out[i] = dout_w[i];
        end
    end

    assign bus.data_e_out = valid_q;
    assign bus.acc_busy   = (state_q == ST_ACC);

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed scoreboard bench for psum_accumulator.
// Two instances: 64 lanes with no shift, 4 lanes with OUT_SHIFT=2.
module tb_psum_accumulator;
    import psum_acc_pkg::*;

    localparam int NC0 = 64;
    localparam int NC1 = 4;

    typedef logic [NC0-1:0][15:0] vec0_t;
    typedef logic [NC1-1:0][15:0] vec1_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    psum_accumulator_if #(.NUM_CH(NC0), .IN_DW(16), .OUT_DW(16)) b0 ();
    psum_accumulator_if #(.NUM_CH(NC1), .IN_DW(16), .OUT_DW(16)) b1 ();

    psum_accumulator #(
        .NUM_CH(NC0), .IN_DW(16), .ACC_DW(24), .OUT_DW(16), .OUT_SHIFT(0)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b0.slave)
    );

    psum_accumulator #(
        .NUM_CH(NC1), .IN_DW(16), .ACC_DW(24), .OUT_DW(16), .OUT_SHIFT(2)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    vec0_t q0[$];
    vec1_t q1[$];

    function automatic vec0_t fill0(input logic [15:0] v);
        vec0_t r;
        for (int i = 0; i < NC0; i++) r[i] = v;
        return r;
    endfunction

    function automatic vec1_t fill1(input logic [15:0] v);
        vec1_t r;
        for (int i = 0; i < NC1; i++) r[i] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc0(input logic e, input vec0_t d);
        b0.data_e  = e;
        b0.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input logic e, input vec1_t d);
        b1.data_e  = e;
        b1.data_in = d;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && b0.data_e_out === 1'b1) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL pix0: got unexpected pulse want none");
            end else begin
                vec0_t e;
                int    k;
                e = q0.pop_front();
                k = -1;
                for (int i = 0; i < NC0; i++) begin
                    if (k < 0 && b0.data_out[i] !== e[i]) k = i;
                end
                if (k >= 0) begin
                    n_bad++;
                    $display("FAIL pix0 lane %0d: got %0d want %0d", k,
                             $signed(b0.data_out[k]), $signed(e[k]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b1.data_e_out === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL pix1: got unexpected pulse want none");
            end else begin
                vec1_t e;
                e = q1.pop_front();
                if (b1.data_out !== e) begin
                    n_bad++;
                    $display("FAIL pix1: got %h want %h", b1.data_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec0_t d;
        vec0_t e;

        b0.mode = 1'b1; b0.beats_cfg = 8'd0; b0.acc_clr = 1'b0;
        b0.data_e = 1'b0; b0.data_in = '0;
        b1.mode = 1'b1; b1.beats_cfg = 8'd0; b1.acc_clr = 1'b0;
        b1.data_e = 1'b0; b1.data_in = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(|b0.data_out), 0);
        chk("rst_valid", 32'(b0.data_e_out), 0);
        chk("rst_busy", 32'(b0.acc_busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // four-beat pixel
        b0.beats_cfg = 8'd4;
        cyc0(1'b1, fill0(16'd10));
        chk("busy_b1", 32'(b0.acc_busy), 1);
        cyc0(1'b1, fill0(16'd20));
        cyc0(1'b1, fill0(16'd30));
        chk("busy_b3", 32'(b0.acc_busy), 1);
        q0.push_back(fill0(16'd100));
        cyc0(1'b1, fill0(16'd40));
        chk("busy_end", 32'(b0.acc_busy), 0);
        cyc0(1'b0, '0);
        cyc0(1'b0, '0);
        chk("hold_l5", 32'(b0.data_out[5]), 100);

        // zero length behaves as one beat per pixel
        b0.beats_cfg = 8'd0;
        repeat (4) begin
            q0.push_back(fill0(16'hFFFB));
            cyc0(1'b1, fill0(16'hFFFB));
        end
        cyc0(1'b0, '0);

        // extremes: clamp or wrap
        b0.beats_cfg = 8'd2;
        d = fill0(16'd0);
        d[0] = 16'h7FFF;
        d[1] = 16'h8000;
        e = fill0(16'd0);
`ifdef PSUM_ACC_SAT_EN
        e[0] = 16'h7FFF;
        e[1] = 16'h8000;
`else
        e[0] = 16'hFFFE;
        e[1] = 16'h0000;
`endif
        cyc0(1'b1, d);
        q0.push_back(e);
        cyc0(1'b1, d);
        cyc0(1'b0, '0);

        // abort drops both the partial pixel and the colliding beat
        b0.beats_cfg = 8'd3;
        cyc0(1'b1, fill0(16'd5));
        b0.acc_clr = 1'b1;
        cyc0(1'b1, fill0(16'd7));
        b0.acc_clr = 1'b0;
        chk("clr_busy", 32'(b0.acc_busy), 0);
        cyc0(1'b1, fill0(16'd1));
        cyc0(1'b1, fill0(16'd1));
        q0.push_back(fill0(16'd3));
        cyc0(1'b1, fill0(16'd1));
        cyc0(1'b0, '0);

        // configuration window mid-pixel, beats_cfg change ignored
        b0.beats_cfg = 8'd3;
        cyc0(1'b1, fill0(16'd2));
        cyc0(1'b1, fill0(16'd3));
        b0.mode = 1'b0;
        b0.beats_cfg = 8'd1;
        for (int i = 0; i < 5; i++) cyc0((i % 2) == 0, fill0(16'd100));
        chk("cfg_busy", 32'(b0.acc_busy), 1);
        b0.mode = 1'b1;
        q0.push_back(fill0(16'd9));
        cyc0(1'b1, fill0(16'd4));
        chk("cfg_done", 32'(b0.acc_busy), 0);
        q0.push_back(fill0(16'd6));
        cyc0(1'b1, fill0(16'd6));
        cyc0(1'b0, '0);

        // back-to-back pixels without a bubble
        b0.beats_cfg = 8'd2;
        cyc0(1'b1, fill0(16'd1));
        q0.push_back(fill0(16'd3));
        cyc0(1'b1, fill0(16'd2));
        cyc0(1'b1, fill0(16'd3));
        q0.push_back(fill0(16'd7));
        cyc0(1'b1, fill0(16'd4));
        cyc0(1'b0, '0);

        // shifted instance: 13>>>2 = 3, -13>>>2 = -4
        b1.beats_cfg = 8'd2;
        cyc1(1'b1, fill1(16'd7));
        q1.push_back(fill1(16'd3));
        cyc1(1'b1, fill1(16'd6));
        cyc1(1'b1, fill1(16'hFFF9));
        q1.push_back(fill1(16'hFFFC));
        cyc1(1'b1, fill1(16'hFFFA));
        cyc1(1'b0, '0);
        chk("sh_hold", 32'(b1.data_out[2]), 32'hFFFC);

        // asynchronous reset mid-pixel on both instances
        b0.beats_cfg = 8'd3;
        b1.data_e = 1'b1;
        b1.data_in = fill1(16'd7);
        cyc0(1'b1, fill0(16'd100));
        b1.data_e = 1'b0;
        b0.data_e = 1'b0;
        chk("pre_busy", 32'(b0.acc_busy), 1);
        rst_n = 1'b0;
        #2;
        chk("ar_dout0", 32'(|b0.data_out), 0);
        chk("ar_dout1", 32'(|b1.data_out), 0);
        chk("ar_valid", 32'(b0.data_e_out), 0);
        chk("ar_busy", 32'(b0.acc_busy | b1.acc_busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        b0.beats_cfg = 8'd2;
        b1.beats_cfg = 8'd2;
        b1.data_e = 1'b1;
        b1.data_in = fill1(16'd7);
        cyc0(1'b1, fill0(16'd1));
        q0.push_back(fill0(16'd2));
        q1.push_back(fill1(16'd3));
        b1.data_in = fill1(16'd6);
        cyc0(1'b1, fill0(16'd1));
        b1.data_e = 1'b0;
        repeat (3) cyc0(1'b0, '0);

        chk("q0_empty", 32'(q0.size()), 0);
        chk("q1_empty", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
